// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the pipelined immediate generator: format select encoding
// and XLEN legality helper used at elaboration time.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_UPC = 3'b101,
    IMM_Z   = 3'b110,
    IMM_ILL = 3'b111
  } imm_fmt_t;

  localparam int XLEN_RV32 = 32;
  localparam int XLEN_RV64 = 64;

  function automatic bit isLegalXlen(input int xlen);
    return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decode: instruction bits [31:7] plus a format select
// in, sign/zero-extended XLEN immediate and an illegal-format flag out.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr_i,
  input  logic [2:0]      immsrc_i,
  output logic [XLEN-1:0] immop_o,
  output logic            illegal_o
);

  imm_fmt_t fmt;
  logic     sign;

  // instr_i[k] carries instruction bit k+7, so instruction bit 31 is instr_i[24].
  assign fmt  = imm_fmt_t'(immsrc_i);
  assign sign = instr_i[24];

  // Start from an all-sign word and overwrite only the low field of each format.
  always_comb begin
    immop_o   = {XLEN{sign}};
    illegal_o = 1'b0;
    case (fmt)
      IMM_I:          immop_o[11:0] = instr_i[24:13];
      IMM_S:          immop_o[11:0] = {instr_i[24:18], instr_i[4:0]};
      IMM_B:          immop_o[11:0] = {instr_i[0], instr_i[23:18], instr_i[4:1], 1'b0};
      IMM_J:          immop_o[19:0] = {instr_i[12:5], instr_i[13], instr_i[23:14], 1'b0};
      IMM_U, IMM_UPC: immop_o[31:0] = {instr_i[24:5], 12'b0};
      IMM_Z:          immop_o       = {{(XLEN-5){1'b0}}, instr_i[12:8]};
      default: begin
        immop_o   = '0;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a registered output stage and one-entry skid
// buffer, giving decode and execute independent valid/ready backpressure.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [24:0]      instr_i,
  input  logic [2:0]       immsrc_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [XLEN-1:0]  immop_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int IMM_W    = XLEN;
  localparam int TAG_BITS = TAG_W;

  typedef struct packed {
    logic [IMM_W-1:0]    immop;
    logic [TAG_BITS-1:0] tag;
    logic                illegal;
  } beat_t;

  if (!isLegalXlen(XLEN)) begin : gBadXlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  decImm;
  logic             decIllegal;
  beat_t            newBeat;
  beat_t            outBeat_q, outBeat_d;
  beat_t            skidBeat_q, skidBeat_d;
  logic             outValid_q, outValid_d;
  logic             skidValid_q, skidValid_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] errCnt_q, errCnt_d;
  logic             accept;
  logic             drain;

  imm_decode #(
    .XLEN(XLEN)
  ) uDecode (
    .instr_i  (instr_i),
    .immsrc_i (immsrc_i),
    .immop_o  (decImm),
    .illegal_o(decIllegal)
  );

  assign newBeat = '{immop: decImm, tag: tag_i, illegal: decIllegal};
  assign accept  = valid_i && ready_q;
  assign drain   = outValid_q && ready_i;

  // A new beat only lands in SKID when OUT is full and not draining; ready is
  // registered from the next SKID state so it never depends on ready_i.
  always_comb begin
    outBeat_d   = outBeat_q;
    outValid_d  = outValid_q;
    skidBeat_d  = skidBeat_q;
    skidValid_d = skidValid_q;
    errCnt_d    = errCnt_q;

    if (drain) begin
      if (skidValid_q) begin
        outBeat_d   = skidBeat_q;
        skidValid_d = 1'b0;
      end else begin
        outValid_d = 1'b0;
      end
    end

    if (accept) begin
      if (!outValid_q || drain) begin
        outBeat_d  = newBeat;
        outValid_d = 1'b1;
      end else begin
        skidBeat_d  = newBeat;
        skidValid_d = 1'b1;
      end
      if (decIllegal && (errCnt_q != {CNT_W{1'b1}})) begin
        errCnt_d = errCnt_q + CNT_W'(1);
      end
    end

    ready_d = !skidValid_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outBeat_q   <= '0;
      outValid_q  <= 1'b0;
      skidBeat_q  <= '0;
      skidValid_q <= 1'b0;
      ready_q     <= 1'b1;
      errCnt_q    <= '0;
    end else begin
      outBeat_q   <= outBeat_d;
      outValid_q  <= outValid_d;
      skidBeat_q  <= skidBeat_d;
      skidValid_q <= skidValid_d;
      ready_q     <= ready_d;
      errCnt_q    <= errCnt_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = outValid_q;
  assign immop_o   = outBeat_q.immop;
  assign tag_o     = outBeat_q.tag;
  assign illegal_o = outBeat_q.illegal;
  assign err_cnt_o = errCnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: an RV32/8-bit-counter and an RV64/2-bit-counter instance
// share one stimulus stream and are checked against a depth-2 in-order FIFO model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [24:0] instr = '0;
  logic [2:0]  immsrc = '0;
  logic [4:0]  tagIn = '0;
  logic        validIn = 1'b0;
  logic        readyIn = 1'b1;

  logic        rdy32, valid32, ill32;
  logic [31:0] immop32;
  logic [4:0]  tag32;
  logic [7:0]  err32;
  logic        rdy64, valid64, ill64;
  logic [63:0] immop64;
  logic [4:0]  tag64;
  logic [1:0]  err64;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } expBeat_t;

  expBeat_t   modelQ[$];
  int         modelErr32 = 0;
  int         modelErr64 = 0;
  int         total = 0;
  int         bad = 0;
  int         phase = 0;
  int         sustainBad = 0;
  bit         sawReadyLow = 1'b0;
  logic [4:0] drainTags[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(8)) u32 (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .immsrc_i(immsrc), .tag_i(tagIn),
    .valid_i(validIn), .ready_o(rdy32), .immop_o(immop32), .tag_o(tag32),
    .illegal_o(ill32), .valid_o(valid32), .ready_i(readyIn), .err_cnt_o(err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(2)) u64 (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .immsrc_i(immsrc), .tag_i(tagIn),
    .valid_i(validIn), .ready_o(rdy64), .immop_o(immop64), .tag_o(tag64),
    .illegal_o(ill64), .valid_o(valid64), .ready_i(readyIn), .err_cnt_o(err64)
  );

  // Sign-extend a w-bit field by shifting it to the top and arithmetic-shifting back.
  function automatic logic [63:0] sext(input logic [63:0] field, input int w);
    logic signed [63:0] t;
    t = $signed(field << (64 - w));
    return t >>> (64 - w);
  endfunction

  function automatic logic [63:0] modelImm(input logic [31:0] ins, input logic [2:0] fmt);
    case (fmt)
      3'd0:    return sext(64'(ins[31:20]), 12);
      3'd1:    return sext(64'({ins[31:25], ins[11:7]}), 12);
      3'd2:    return sext(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      3'd3:    return sext(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      3'd4,
      3'd5:    return sext(64'({ins[31:12], 12'b0}), 32);
      3'd6:    return 64'(ins[19:15]);
      default: return 64'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Model: a two-deep in-order queue; block accepts while fewer than two beats are held.
  always @(posedge clk or posedge rst) begin : modelUpdate
    bit acc;
    bit drn;
    expBeat_t b;
    if (rst) begin
      modelQ.delete();
      modelErr32 = 0;
      modelErr64 = 0;
    end else begin
      acc = validIn && (modelQ.size() < 2);
      drn = (modelQ.size() > 0) && readyIn;
      if (drn) void'(modelQ.pop_front());
      if (acc) begin
        b.imm = modelImm({instr, 7'b0}, immsrc);
        b.tag = tagIn;
        b.ill = (immsrc == 3'b111);
        modelQ.push_back(b);
        if (b.ill) begin
          if (modelErr32 < 255) modelErr32++;
          if (modelErr64 < 3) modelErr64++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("valid32", 64'(valid32), 64'(modelQ.size() > 0));
      checkOutput("valid64", 64'(valid64), 64'(modelQ.size() > 0));
      checkOutput("ready32", 64'(rdy32), 64'(modelQ.size() < 2));
      checkOutput("ready64", 64'(rdy64), 64'(modelQ.size() < 2));
      checkOutput("err32", 64'(err32), 64'(modelErr32));
      checkOutput("err64", 64'(err64), 64'(modelErr64));
      if (modelQ.size() > 0) begin
        checkOutput("imm32", 64'(immop32), 64'(modelQ[0].imm[31:0]));
        checkOutput("imm64", immop64, modelQ[0].imm);
        checkOutput("tag32", 64'(tag32), 64'(modelQ[0].tag));
        checkOutput("tag64", 64'(tag64), 64'(modelQ[0].tag));
        checkOutput("ill32", 64'(ill32), 64'(modelQ[0].ill));
        checkOutput("ill64", 64'(ill64), 64'(modelQ[0].ill));
        if (readyIn) drainTags.push_back(tag64);
      end
      if (!rdy64) sawReadyLow = 1'b1;
      if (phase == 5 && (!rdy64 || !valid64)) sustainBad++;
    end
  end

  // Present one beat and hold it until it is accepted; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] ins, input logic [2:0] fmt, input logic [4:0] tag);
    bit acc;
    int n;
    instr   = ins[31:7];
    immsrc  = fmt;
    tagIn   = tag;
    validIn = 1'b1;
    n = 0;
    do begin
      acc = rdy64;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    validIn = 1'b0;
    checkOutput("accept", 64'(acc), 64'd1);
  endtask

  task automatic sendAndCheck(input string name, input logic [31:0] ins, input logic [2:0] fmt,
                              input logic [4:0] tag, input logic [63:0] exp64, input logic expIll);
    checkOutput({name, "_model"}, modelImm(ins, fmt), exp64);
    applyStimulus(ins, fmt, tag);
    checkOutput({name, "_valid"}, 64'(valid64), 64'd1);
    checkOutput({name, "_imm64"}, immop64, exp64);
    checkOutput({name, "_imm32"}, 64'(immop32), 64'(exp64[31:0]));
    checkOutput({name, "_ill"}, 64'(ill64), 64'(expIll));
    checkOutput({name, "_tag"}, 64'(tag32), 64'(tag));
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (modelQ.size() > 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 64'(modelQ.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 64'(valid64), 64'd0);
    checkOutput("rst_ready", 64'(rdy64), 64'd1);
    checkOutput("rst_imm", immop64, 64'd0);
    checkOutput("rst_tag", 64'(tag64), 64'd0);
    checkOutput("rst_ill", 64'(ill64), 64'd0);
    checkOutput("rst_err", 64'(err32), 64'd0);
    rst = 1'b0;

    sendAndCheck("I",   32'hFFF00093, 3'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    sendAndCheck("S",   32'hFE112E23, 3'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    sendAndCheck("B",   32'hFE000EE3, 3'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    sendAndCheck("J",   32'hFF9FF06F, 3'd3, 5'd4, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    sendAndCheck("Uneg",32'h80000037, 3'd4, 5'd5, 64'hFFFF_FFFF_8000_0000, 1'b0);
    sendAndCheck("Upos",32'h12345037, 3'd4, 5'd6, 64'h0000_0000_1234_5000, 1'b0);
    sendAndCheck("UPC", 32'h12345017, 3'd5, 5'd7, 64'h0000_0000_1234_5000, 1'b0);
    sendAndCheck("Z",   32'h000FD073, 3'd6, 5'd8, 64'h0000_0000_0000_001F, 1'b0);
    sendAndCheck("ILL", 32'hFFFFFFFF, 3'd7, 5'd9, 64'h0, 1'b1);
    checkOutput("ill_err32", 64'(err32), 64'd1);
    checkOutput("ill_err64", 64'(err64), 64'd1);
    waitDrain("drain_directed");

    $display("[TB] backpressure stream");
    drainTags.delete();
    sawReadyLow = 1'b0;
    fork
      begin
        for (int t = 1; t <= 4; t++) applyStimulus(32'h00000093 | (32'(t) << 20), 3'd0, 5'(t));
      end
      begin
        @(posedge clk);
        #1 readyIn = 1'b0;
        repeat (4) @(posedge clk);
        #1 readyIn = 1'b1;
      end
    join
    waitDrain("drain_bp");
    checkOutput("bp_readyLow", 64'(sawReadyLow), 64'd1);
    checkOutput("bp_count", 64'(drainTags.size()), 64'd4);
    for (int i = 0; i < 4 && i < drainTags.size(); i++)
      checkOutput("bp_order", 64'(drainTags[i]), 64'(i + 1));

    $display("[TB] illegal saturation");
    for (int i = 0; i < 5; i++) applyStimulus(32'hFFFFFFFF, 3'd7, 5'(20 + i));
    checkOutput("sat_err64", 64'(err64), 64'd3);
    checkOutput("sat_err32", 64'(err32), 64'd6);
    waitDrain("drain_sat");

    $display("[TB] reset mid-operation");
    readyIn = 1'b0;
    applyStimulus(32'h00A00093, 3'd0, 5'd10);
    applyStimulus(32'h00B00093, 3'd0, 5'd11);
    checkOutput("full_ready", 64'(rdy64), 64'd0);
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_valid32", 64'(valid32), 64'd0);
    checkOutput("arst_valid64", 64'(valid64), 64'd0);
    checkOutput("arst_ready", 64'(rdy64), 64'd1);
    checkOutput("arst_err32", 64'(err32), 64'd0);
    checkOutput("arst_err64", 64'(err64), 64'd0);
    checkOutput("arst_imm", immop64, 64'd0);
    checkOutput("arst_tag", 64'(tag64), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    readyIn = 1'b1;
    sendAndCheck("postRst", 32'h7FF00093, 3'd0, 5'd12, 64'h7FF, 1'b0);
    waitDrain("drain_rst");

    $display("[TB] sustained accept and drain");
    sustainBad = 0;
    applyStimulus(32'h00100093, 3'd0, 5'd0);
    phase = 5;
    for (int i = 1; i <= 20; i++) applyStimulus(32'h00000093 | (32'(i) << 20), 3'd0, 5'(i));
    phase = 0;
    checkOutput("sustain", 64'(sustainBad), 64'd0);
    waitDrain("drain_sustain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
